// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default widths, the ID/EX control
// word layout, and the set of control bits that must read 0 in a bubble.
package pipe_pkg;

  // Default datapath widths for the 32-bit core.
  localparam int DEF_PC_W     = 5;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_REG_W    = 5;
  localparam int DEF_ALU_OP_W = 5;

  // ID/EX control word. alu_src sits in bit 0, mem_to_reg in bit 4.
  typedef struct packed {
    logic mem_to_reg;
    logic mem_wrenable;
    logic reg_wrenable;
    logic is_jump;
    logic alu_src;
  } id_ex_ctrl_t;

  localparam int CTRL_W            = 5;
  localparam int CTRL_ALU_SRC_OFS  = 0;
  localparam int CTRL_IS_JUMP_OFS  = 1;
  localparam int CTRL_REG_WE_OFS   = 2;
  localparam int CTRL_MEM_WE_OFS   = 3;
  localparam int CTRL_MEM_TO_REG_OFS = 4;

  // Control bits with architectural side effects; a bubble must carry them
  // as 0 so a killed instruction never writes, stores or redirects.
  localparam logic [CTRL_W-1:0] GATED_CTRL_MASK =
    (5'b00001 << CTRL_IS_JUMP_OFS) |
    (5'b00001 << CTRL_REG_WE_OFS)  |
    (5'b00001 << CTRL_MEM_WE_OFS);

  // Assemble the control word from its individual decode outputs.
  function automatic id_ex_ctrl_t pack_ctrl(
    input logic alu_src,
    input logic is_jump,
    input logic reg_wrenable,
    input logic mem_wrenable,
    input logic mem_to_reg
  );
    id_ex_ctrl_t c;
    c.alu_src      = alu_src;
    c.is_jump      = is_jump;
    c.reg_wrenable = reg_wrenable;
    c.mem_wrenable = mem_wrenable;
    c.mem_to_reg   = mem_to_reg;
    return c;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with a one-entry skid slot and flush.
// in_ready is a flop (inverse of the skid valid bit), so there is no
// combinational path from out_ready to in_ready. Bits selected by CLR_MASK
// are registered as 0 whenever the main slot goes empty.
module pipe_skid_reg #(
  parameter int           W        = 8,
  parameter logic [W-1:0] CLR_MASK = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid_q, main_valid_d;
  logic [W-1:0] main_data_q,  main_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q,  skid_data_d;
  logic         accept_s;
  logic         consume_s;

  assign accept_s  = in_valid && !skid_valid_q && !flush;
  assign consume_s = main_valid_q && out_ready;

  // Next-state for both slots: flush empties everything, otherwise the main
  // slot refills from skid first (FIFO order), then from the input.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || consume_s) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
        // Unreachable while in_ready tracks !skid_valid, kept for safety.
        if (accept_s) begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end else begin
          skid_data_d  = skid_data_q;
        end
      end else if (accept_s) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end else begin
      main_valid_d = main_valid_q;
    end
    // A bubble carries its side-effect bits as 0 in the register itself.
    if (!main_valid_d) begin
      main_data_d = main_data_d & ~CLR_MASK;
    end else begin
      main_data_d = main_data_d;
    end
  end

  // State registers with synchronous reset clearing valid bits and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_data_q  <= {W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {W{1'b0}};
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register: packs decode outputs into one payload, passes it
// through a skid-buffered valid/ready register, and unpacks it for EX.
// Jump / register-write / memory-write bits are cleared in the register
// whenever the stage holds a bubble.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter int PC_W     = DEF_PC_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int ALU_OP_W = DEF_ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]   in_rd1,
  input  logic [DATA_W-1:0]   in_rd2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic                in_alu_src,
  input  logic                in_is_jump,
  input  logic                in_reg_wrenable,
  input  logic                in_mem_wrenable,
  input  logic                in_mem_to_reg,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic [REG_W-1:0]    in_write_reg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [DATA_W-1:0]   out_rd1,
  output logic [DATA_W-1:0]   out_rd2,
  output logic [DATA_W-1:0]   out_imm,
  output logic                out_alu_src,
  output logic                out_is_jump,
  output logic                out_reg_wrenable,
  output logic                out_mem_wrenable,
  output logic                out_mem_to_reg,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic [REG_W-1:0]    out_write_reg
);

  // Payload layout, MSB first: ctrl | alu_op | write_reg | imm | rd2 | rd1 | pc
  localparam int PAYLOAD_W = CTRL_W + ALU_OP_W + REG_W + 3 * DATA_W + PC_W;
  localparam logic [PAYLOAD_W-1:0] BUBBLE_MASK =
    {GATED_CTRL_MASK, {(PAYLOAD_W - CTRL_W){1'b0}}};

  id_ex_ctrl_t            in_ctrl_s;
  id_ex_ctrl_t            out_ctrl_s;
  logic [PAYLOAD_W-1:0]   in_payload_s;
  logic [PAYLOAD_W-1:0]   out_payload_s;

  assign in_ctrl_s = pack_ctrl(in_alu_src, in_is_jump, in_reg_wrenable,
                               in_mem_wrenable, in_mem_to_reg);

  assign in_payload_s = {in_ctrl_s, in_alu_op, in_write_reg,
                         in_imm, in_rd2, in_rd1, in_pc};

  pipe_skid_reg #(
    .W        (PAYLOAD_W),
    .CLR_MASK (BUBBLE_MASK)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_payload_s)
  );

  assign {out_ctrl_s, out_alu_op, out_write_reg,
          out_imm, out_rd2, out_rd1, out_pc} = out_payload_s;

  // Gated bits arrive already cleared for bubbles; no masking needed here.
  assign out_alu_src      = out_ctrl_s.alu_src;
  assign out_is_jump      = out_ctrl_s.is_jump;
  assign out_reg_wrenable = out_ctrl_s.reg_wrenable;
  assign out_mem_wrenable = out_ctrl_s.mem_wrenable;
  assign out_mem_to_reg   = out_ctrl_s.mem_to_reg;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed-vector and queue-model bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- default-width DUT ----------------
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_pc, out_pc, in_alu_op, out_alu_op, in_write_reg, out_write_reg;
  logic [31:0] in_rd1, in_rd2, in_imm, out_rd1, out_rd2, out_imm;
  logic        in_alu_src, in_is_jump, in_reg_wrenable, in_mem_wrenable, in_mem_to_reg;
  logic        out_alu_src, out_is_jump, out_reg_wrenable, out_mem_wrenable, out_mem_to_reg;

  id_ex_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rd1(in_rd1), .in_rd2(in_rd2), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_is_jump(in_is_jump),
    .in_reg_wrenable(in_reg_wrenable), .in_mem_wrenable(in_mem_wrenable),
    .in_mem_to_reg(in_mem_to_reg), .in_alu_op(in_alu_op), .in_write_reg(in_write_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_alu_src(out_alu_src), .out_is_jump(out_is_jump),
    .out_reg_wrenable(out_reg_wrenable), .out_mem_wrenable(out_mem_wrenable),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_op(out_alu_op), .out_write_reg(out_write_reg)
  );

  // ---------------- narrow DUT (DATA_W=16, PC_W=8) ----------------
  logic        p_rst, p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [7:0]  p_in_pc, p_out_pc;
  logic [15:0] p_in_rd1, p_in_rd2, p_in_imm, p_out_rd1, p_out_rd2, p_out_imm;
  logic [4:0]  p_in_alu_op, p_out_alu_op, p_in_write_reg, p_out_write_reg;
  logic        p_in_alu_src, p_in_is_jump, p_in_reg_we, p_in_mem_we, p_in_m2r;
  logic        p_out_alu_src, p_out_is_jump, p_out_reg_we, p_out_mem_we, p_out_m2r;

  id_ex_pipe_reg #(.PC_W(8), .DATA_W(16)) dut16 (
    .clk(clk), .rst(p_rst), .flush(p_flush),
    .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_pc(p_in_pc), .in_rd1(p_in_rd1), .in_rd2(p_in_rd2), .in_imm(p_in_imm),
    .in_alu_src(p_in_alu_src), .in_is_jump(p_in_is_jump),
    .in_reg_wrenable(p_in_reg_we), .in_mem_wrenable(p_in_mem_we),
    .in_mem_to_reg(p_in_m2r), .in_alu_op(p_in_alu_op), .in_write_reg(p_in_write_reg),
    .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_pc(p_out_pc), .out_rd1(p_out_rd1), .out_rd2(p_out_rd2), .out_imm(p_out_imm),
    .out_alu_src(p_out_alu_src), .out_is_jump(p_out_is_jump),
    .out_reg_wrenable(p_out_reg_we), .out_mem_wrenable(p_out_mem_we),
    .out_mem_to_reg(p_out_m2r), .out_alu_op(p_out_alu_op), .out_write_reg(p_out_write_reg)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Payload fields derived from a key, so every instruction is recognisable.
  typedef struct {
    logic [4:0]  pc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  alu_op, wr;
    logic        alu_src, is_jump, reg_we, mem_we, m2r;
  } fld_t;

  function automatic fld_t gen(input logic [31:0] k);
    fld_t f;
    f.pc      = k[4:0];
    f.rd1     = 32'hA000_0000 + k;
    f.rd2     = ~k;
    f.imm     = k * 32'd7;
    f.alu_op  = k[9:5] ^ 5'h15;
    f.wr      = ~k[4:0];
    f.alu_src = k[1];
    f.is_jump = k[0];
    f.reg_we  = 1'b1;
    f.mem_we  = ~k[0];
    f.m2r     = k[2];
    return f;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] k);
    fld_t f;
    f = gen(k);
    in_valid = v; in_pc = f.pc; in_rd1 = f.rd1; in_rd2 = f.rd2; in_imm = f.imm;
    in_alu_op = f.alu_op; in_write_reg = f.wr; in_alu_src = f.alu_src;
    in_is_jump = f.is_jump; in_reg_wrenable = f.reg_we;
    in_mem_wrenable = f.mem_we; in_mem_to_reg = f.m2r;
  endtask

  task automatic check_state(input string tag, input logic e_vld,
                             input logic [31:0] e_key, input logic e_rdy);
    fld_t f;
    f = gen(e_key);
    chk({tag, " out_valid"}, out_valid, e_vld);
    chk({tag, " in_ready"}, in_ready, e_rdy);
    if (e_vld) begin
      chk({tag, " pc"}, out_pc, f.pc);
      chk({tag, " rd1"}, out_rd1, f.rd1);
      chk({tag, " rd2"}, out_rd2, f.rd2);
      chk({tag, " imm"}, out_imm, f.imm);
      chk({tag, " alu_op"}, out_alu_op, f.alu_op);
      chk({tag, " write_reg"}, out_write_reg, f.wr);
      chk({tag, " ctrl"}, {out_alu_src, out_is_jump, out_reg_wrenable,
                           out_mem_wrenable, out_mem_to_reg},
          {f.alu_src, f.is_jump, f.reg_we, f.mem_we, f.m2r});
    end else begin
      chk({tag, " bubble ctrl"}, {out_is_jump, out_reg_wrenable, out_mem_wrenable}, 3'b000);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " zero pc"}, out_pc, 32'h0);
    chk({tag, " zero rd1"}, out_rd1, 32'h0);
    chk({tag, " zero rd2"}, out_rd2, 32'h0);
    chk({tag, " zero imm"}, out_imm, 32'h0);
    chk({tag, " zero alu_op"}, out_alu_op, 32'h0);
    chk({tag, " zero write_reg"}, out_write_reg, 32'h0);
    chk({tag, " zero ctrl"}, {out_alu_src, out_is_jump, out_reg_wrenable,
                              out_mem_wrenable, out_mem_to_reg}, 32'h0);
  endtask

  // Directed vector: inputs before the edge, expected state after it.
  typedef struct {
    logic       rst, flush, vld;
    logic [4:0] pc;
    logic       ordy;
    logic       e_vld;
    logic [4:0] e_pc;
    logic       e_rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic fl, input logic v,
                              input logic [4:0] pc, input logic o,
                              input logic ev, input logic [4:0] ep, input logic er);
    vec_t t;
    t.rst = r; t.flush = fl; t.vld = v; t.pc = pc; t.ordy = o;
    t.e_vld = ev; t.e_pc = ep; t.e_rdy = er;
    return t;
  endfunction

  int unsigned mq[$];
  logic [31:0] seq;
  logic        s_iv, s_or, s_fl;
  int          sz;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; drive(1'b1, 32'd1);
    p_rst = 1'b1; p_flush = 1'b0; p_in_valid = 1'b0; p_out_ready = 1'b1;
    p_in_pc = 8'h00; p_in_rd1 = 16'h0; p_in_rd2 = 16'h0; p_in_imm = 16'h0;
    p_in_alu_op = 5'h0; p_in_write_reg = 5'h0; p_in_alu_src = 1'b0;
    p_in_is_jump = 1'b0; p_in_reg_we = 1'b0; p_in_mem_we = 1'b0; p_in_m2r = 1'b0;

    //             rst   fl    vld   pc      ordy  e_vld e_pc    e_rdy
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 5'd0,  1'b1));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 5'd1,  1'b1, 1'b0, 5'd0,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'h03, 1'b1, 1'b1, 5'h03, 1'b1));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'(i), 1'b1, 1'b1, 5'(i), 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1));
    // back-pressure: 2 in main, 3 to skid, 4 held, then drain 2,3,4
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 5'd2,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd3,  1'b0, 1'b1, 5'd2,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd4,  1'b0, 1'b1, 5'd2,  1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 5'd3,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 5'd4,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1));
    // flush with both slots full and 12 offered
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 5'd10, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd11, 1'b0, 1'b1, 5'd10, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd12, 1'b0, 1'b0, 5'd0,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1));
    // flush on empty block with an input offered
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd13, 1'b1, 1'b0, 5'd0,  1'b1));
    // flush together with consume
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd14, 1'b1, 1'b1, 5'd14, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0, 5'd0,  1'b1));
    // reset mid-operation with both slots full
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd16, 1'b0, 1'b1, 5'd16, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd17, 1'b0, 1'b1, 5'd16, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, 1'b1, 5'd18, 1'b0, 1'b0, 5'd0,  1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b1, 5'd19, 1'b1, 1'b1, 5'd19, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b1));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; out_ready = tbl[i].ordy;
      drive(tbl[i].vld, {27'd0, tbl[i].pc});
      @(posedge clk); #1;
      check_state($sformatf("vec%0d", i), tbl[i].e_vld, {27'd0, tbl[i].e_pc}, tbl[i].e_rdy);
      if (tbl[i].rst) check_zero($sformatf("vec%0d", i));
    end

    // Narrow instance: release reset, stream 8 instructions with imm BEEF.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w16 reset out_valid", p_out_valid, 1'b0);
    chk("w16 reset in_ready", p_in_ready, 1'b1);
    p_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p_in_valid = 1'b1; p_in_pc = 8'h80 + 8'(i); p_in_rd1 = 16'hA000 + 16'(i);
      p_in_rd2 = 16'h0F00 ^ 16'(i); p_in_imm = 16'hBEEF; p_in_alu_op = 5'(i);
      p_in_write_reg = 5'(31 - i); p_in_alu_src = i[0]; p_in_is_jump = i[1];
      p_in_reg_we = 1'b1; p_in_mem_we = i[2]; p_in_m2r = ~i[0];
      @(posedge clk); #1;
      chk($sformatf("w16 s%0d valid", i), p_out_valid, 1'b1);
      chk($sformatf("w16 s%0d pc", i), p_out_pc, 8'h80 + 8'(i));
      chk($sformatf("w16 s%0d rd1", i), p_out_rd1, 16'hA000 + 16'(i));
      chk($sformatf("w16 s%0d rd2", i), p_out_rd2, 16'h0F00 ^ 16'(i));
      chk($sformatf("w16 s%0d imm", i), p_out_imm, 16'hBEEF);
      chk($sformatf("w16 s%0d op/wr", i), {p_out_alu_op, p_out_write_reg},
          {5'(i), 5'(31 - i)});
      chk($sformatf("w16 s%0d ctrl", i),
          {p_out_alu_src, p_out_is_jump, p_out_reg_we, p_out_mem_we, p_out_m2r},
          {i[0], i[1], 1'b1, i[2], ~i[0]});
    end
    p_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("w16 drain valid", p_out_valid, 1'b0);
    chk("w16 drain ctrl", {p_out_is_jump, p_out_reg_we, p_out_mem_we}, 3'b000);

    // Random stall/flush soak against a two-deep FIFO model.
    rst = 1'b0; seq = 32'd1000; mq.delete();
    for (int c = 0; c < 10000; c++) begin
      s_iv = ($urandom_range(3) != 0);
      s_or = ($urandom_range(2) != 0);
      s_fl = ($urandom_range(31) == 0);
      flush = s_fl; out_ready = s_or;
      drive(s_iv, seq);
      sz = mq.size();
      if (s_fl) begin
        mq.delete();
      end else begin
        if (sz > 0 && s_or) void'(mq.pop_front());
        if (s_iv && sz < 2) begin
          mq.push_back(seq);
          seq = seq + 32'd1;
        end
      end
      @(posedge clk); #1;
      if (mq.size() > 0) check_state($sformatf("soak%0d", c), 1'b1, mq[0], mq.size() < 2);
      else check_state($sformatf("soak%0d", c), 1'b0, 32'd0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_reg.md
# id_ex_pipe_reg

Parametrised ID→EX pipeline register with a valid/ready handshake, a one-entry skid buffer, and a flush input. It sits between decode and execute, where it replaces the free-running buffer. It adds three things: back-pressure from EX, bubble insertion on branch/jump flush, and a synchronous reset. Widths are generic so the same block serves the 32-bit core and narrower test cores.

## Interface
Parameters:
- PC_W, 5: program-counter width
- DATA_W, 32: width of rd1/rd2/imm
- REG_W, 5: register-index width
- ALU_OP_W, 5: ALU opcode width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill every held and incoming instruction this cycle
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  block can accept; registered (equals !skid_valid)
- in_pc / in_rd1 / in_rd2 / in_imm  in  PC_W / DATA_W / DATA_W / DATA_W  payload data
- in_alu_src, in_is_jump, in_reg_wrenable, in_mem_wrenable, in_mem_to_reg  in  1 each  control
- in_alu_op  in  ALU_OP_W;  in_write_reg  in  REG_W
- out_valid  out  1  EX stage holds a live instruction
- out_ready  in  1  EX consumes the current instruction
- out_* (same eleven fields)  out  matching widths  registered payload

## Operation
- Storage: a main slot (drives out_*) and a skid slot, each with its own valid bit.
- Accept: in_valid && in_ready && !flush. Consume: out_valid && out_ready.
- Next-state priority, highest first:
  1. rst
  2. flush
  3. normal
- rst: main_valid = skid_valid = 0; every out_* = 0; in_ready = 1.
- flush (rst low): main_valid = skid_valid = 0; the input offered that cycle is dropped; in_ready = 1 next cycle. Data fields may hold stale values.
- Normal operation:
  - Main empty or consumed, skid valid: main ← skid; skid_valid = 0. If an accept also occurs, the input goes to skid. This cannot happen, because in_ready = 0 whenever skid is valid.
  - Main empty or consumed, skid empty: main ← input if accepted, else main_valid = 0.
  - Main full and not consumed, accept: skid ← input; skid_valid = 1.
  - Main full and not consumed, no accept: hold.
- Bubble gating: whenever main_valid is 0, out_reg_wrenable, out_mem_wrenable and out_is_jump read 0. These three are registered as cleared, not masked combinationally. out_valid is always the main valid bit.
- Ordering: strict FIFO order. Skid contents always leave before any later input.
- No payload field is modified; fields are copied bit-exact.

## Timing
- Latency: 1 cycle from accept to out_valid when the block is empty.
- Throughput: 1 instruction per cycle while out_ready = 1.
- Back-pressure:
  - When out_ready falls with main full, one further accepted instruction lands in skid.
  - in_ready falls the following cycle, so in_ready has no combinational path from out_ready.
- Recovery: after out_ready rises, skid moves to main on the next edge and in_ready returns to 1 on that same edge.
- Flush takes effect on the edge where it is sampled high. out_valid = 0 and the gated controls are 0 in the following cycle.
- Simultaneous flush and consume: the consume still counts for EX. The block empties regardless.
- rst mid-operation behaves the same as flush and additionally zeroes all data fields.

## Structure
- Shared package pipe_pkg:
  - default widths: PC_W, DATA_W, REG_W, ALU_OP_W
  - id_ex_ctrl field packing and offsets
  - the list of gated control bits (reg_wrenable, mem_wrenable, is_jump), reused by later EX/MEM and MEM/WB registers
- Sub-module pipe_skid_reg:
  - generic over payload width W
  - handles valid/ready, the skid slot and flush
- id_ex_pipe_reg packs all fields into one payload vector, instantiates pipe_skid_reg, unpacks the output, and applies bubble gating.

## Test plan
- Reset: assert rst for 2 cycles with in_valid = 1, in_reg_wrenable = 1 → out_valid = 0, all out_* = 0, in_ready = 1. Release: the first accept with pc = 5'h03 appears on out_pc next cycle with out_valid = 1.
- Streaming: out_ready = 1, 8 back-to-back instructions with pc 0..7, rd1 = 32'hA000_0000+pc → out_pc 0..7 on consecutive cycles, 1-cycle latency, no gaps.
- Back-pressure: drop out_ready with pc = 2 in main while pc = 3 is offered → pc = 3 goes to skid; in_ready = 0 next cycle; pc = 4 is held by decode. Raise out_ready → output sequence is 2, 3, 4 with nothing lost or duplicated.
- Flush with both slots full (pc 10, 11) and pc = 12 offered → next cycle out_valid = 0, out_reg_wrenable = out_mem_wrenable = out_is_jump = 0, in_ready = 1. pc 10/11/12 never appear.
- Parametrisation: instantiate DATA_W = 16, PC_W = 8, rerun streaming with imm = 16'hBEEF → exact field match.
- Random stall/flush soak, 10k cycles, checked against a queue model: order preserved, no control bit set while out_valid = 0.
